ps2_host_tx: RTL and testbench



---
 rtl/ps2_host_tx.sv | 206 ++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send and
// shifts one command byte (LSB first, odd parity, stop) out on device clock edges.
module ps2_host_tx #(
    parameter int unsigned CLK_FREQ_HZ      = 97_500_000,
    parameter int unsigned INHIBIT_US       = 120,
    parameter int unsigned START_TIMEOUT_US = 15000,
    parameter int unsigned FRAME_TIMEOUT_US = 2000,
    parameter int unsigned FILTER_LEN       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       rx_inhibit,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code
);

    localparam int unsigned TICK_DIV = (CLK_FREQ_HZ / 1_000_000 > 0) ? CLK_FREQ_HZ / 1_000_000 : 1;
    localparam int unsigned TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned TMR_MAX  = (INHIBIT_US > START_TIMEOUT_US) ? INHIBIT_US : START_TIMEOUT_US;
    localparam int unsigned TMR_W    = $clog2(TMR_MAX + 1);
    localparam int unsigned FRM_W    = $clog2(FRAME_TIMEOUT_US + 1);
    localparam int unsigned FLT_W    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_BITS,
        S_ACK,
        S_WAIT_IDLE,
        S_DONE,
        S_ABORT
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        clk_sync_q, clk_sync_d;
    logic [1:0]        data_sync_q, data_sync_d;
    logic [FLT_W-1:0]  clk_flt_cnt_q, clk_flt_cnt_d;
    logic [FLT_W-1:0]  data_flt_cnt_q, data_flt_cnt_d;
    logic              clk_filt_q, clk_filt_d;
    logic              data_filt_q, data_filt_d;
    logic              clk_prev_q, clk_prev_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [FRM_W-1:0]  frm_q, frm_d;
    logic [8:0]        shreg_q, shreg_d;
    logic [3:0]        bit_idx_q, bit_idx_d;
    logic              data_oe_q, data_oe_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              tick;
    logic              fall;
    logic              frame_exp;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            clk_sync_q     <= '1;
            data_sync_q    <= '1;
            clk_flt_cnt_q  <= '0;
            data_flt_cnt_q <= '0;
            clk_filt_q     <= 1'b1;
            data_filt_q    <= 1'b1;
            clk_prev_q     <= 1'b1;
            tick_cnt_q     <= '0;
            tmr_q          <= '0;
            frm_q          <= '0;
            shreg_q        <= '0;
            bit_idx_q      <= '0;
            data_oe_q      <= 1'b0;
            err_code_q     <= '0;
        end else begin
            state_q        <= state_d;
            clk_sync_q     <= clk_sync_d;
            data_sync_q    <= data_sync_d;
            clk_flt_cnt_q  <= clk_flt_cnt_d;
            data_flt_cnt_q <= data_flt_cnt_d;
            clk_filt_q     <= clk_filt_d;
            data_filt_q    <= data_filt_d;
            clk_prev_q     <= clk_prev_d;
            tick_cnt_q     <= tick_cnt_d;
            tmr_q          <= tmr_d;
            frm_q          <= frm_d;
            shreg_q        <= shreg_d;
            bit_idx_q      <= bit_idx_d;
            data_oe_q      <= data_oe_d;
            err_code_q     <= err_code_d;
        end
    end

    // A line level is accepted only after FILTER_LEN consecutive differing samples.
    always_comb begin
        clk_sync_d     = {clk_sync_q[0], ps2_clk_in};
        data_sync_d    = {data_sync_q[0], ps2_data_in};
        clk_flt_cnt_d  = '0;
        data_flt_cnt_d = '0;
        clk_filt_d     = clk_filt_q;
        data_filt_d    = data_filt_q;
        if (clk_sync_q[1] != clk_filt_q) begin
            if (clk_flt_cnt_q == FLT_W'(FILTER_LEN - 1)) clk_filt_d = clk_sync_q[1];
            else                                        clk_flt_cnt_d = clk_flt_cnt_q + 1'b1;
        end
        if (data_sync_q[1] != data_filt_q) begin
            if (data_flt_cnt_q == FLT_W'(FILTER_LEN - 1)) data_filt_d = data_sync_q[1];
            else                                         data_flt_cnt_d = data_flt_cnt_q + 1'b1;
        end
        clk_prev_d = clk_filt_q;
        fall       = clk_prev_q & ~clk_filt_q;
        tick       = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_idx_d  = bit_idx_q;
        data_oe_d  = data_oe_q;
        err_code_d = err_code_q;
        frm_d      = tick ? frm_q + 1'b1 : frm_q;
        frame_exp  = tick && (frm_q == FRM_W'(FRAME_TIMEOUT_US - 1));
        unique case (state_q)
            S_IDLE: begin
                if (tx_valid) begin
                    shreg_d    = {~^tx_data, tx_data};
                    err_code_d = '0;
                    state_d    = S_INHIBIT;
                end
            end
            // Data goes low one cycle before the clock is released.
            S_INHIBIT: begin
                if (data_oe_q)                                          state_d = S_REQ;
                else if (tick && tmr_q == TMR_W'(INHIBIT_US - 1))       data_oe_d = 1'b1;
            end
            S_REQ: begin
                if (tick && tmr_q == TMR_W'(START_TIMEOUT_US - 1)) begin
                    data_oe_d  = 1'b0;
                    err_code_d = 2'b01;
                    state_d    = S_ABORT;
                end else if (fall) begin
                    data_oe_d = ~shreg_q[0];
                    bit_idx_d = 4'd1;
                    frm_d     = '0;
                    state_d   = S_BITS;
                end
            end
            S_BITS: begin
                if (frame_exp) begin
                    data_oe_d  = 1'b0;
                    err_code_d = 2'b10;
                    state_d    = S_ABORT;
                end else if (fall) begin
                    if (bit_idx_q == 4'd9) begin
                        data_oe_d = 1'b0;
                        state_d   = S_ACK;
                    end else begin
                        data_oe_d = ~shreg_q[bit_idx_q];
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            S_ACK: begin
                if (frame_exp) begin
                    err_code_d = 2'b10;
                    state_d    = S_ABORT;
                end else if (fall) begin
                    if (!data_filt_q) begin
                        state_d = S_WAIT_IDLE;
                    end else begin
                        err_code_d = 2'b11;
                        state_d    = S_ABORT;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (frame_exp) begin
                    err_code_d = 2'b10;
                    state_d    = S_ABORT;
                end else if (clk_filt_q && data_filt_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ABORT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        tmr_d = (state_d != state_q) ? '0 : (tick ? tmr_q + 1'b1 : tmr_q);
    end

    always_comb begin
        tx_ready    = (state_q == S_IDLE);
        rx_inhibit  = (state_q != S_IDLE);
        ps2_clk_oe  = (state_q == S_INHIBIT);
        ps2_data_oe = data_oe_q;
        done        = (state_q == S_DONE);
        err         = (state_q == S_ABORT);
        err_code    = err_code_q;
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomised scoreboard bench for ps2_host_tx with an open-drain PS/2 device model.
module tb_ps2_host_tx;

    localparam int unsigned CLK_HZ   = 8_000_000;
    localparam int          DIV      = 8;
    localparam int unsigned INH      = 12;
    localparam int unsigned START_TO = 300;
    localparam int unsigned FRAME_TO = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_ready, ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
    logic       rx_inhibit, done, err;
    logic [1:0] err_code;
    logic       dev_clk_low = 1'b0, dev_data_low = 1'b0, glitch = 1'b0;

    assign ps2_clk_in  = !(ps2_clk_oe || dev_clk_low || glitch);
    assign ps2_data_in = !(ps2_data_oe || dev_data_low);

    ps2_host_tx #(
        .CLK_FREQ_HZ(CLK_HZ),
        .INHIBIT_US(INH),
        .START_TIMEOUT_US(START_TO),
        .FRAME_TIMEOUT_US(FRAME_TO),
        .FILTER_LEN(4)
    ) dut (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .rx_inhibit(rx_inhibit),
        .done(done), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [1:0] code;
        logic [9:0] frame;
        int         ref_sel;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         t_release = 0;
    int         t_first_fall = 0;
    int         inh_cnt = 0;
    logic       prev_oe = 1'b0;
    logic [9:0] cap_frame = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic chk_range(input string name, input int val, input int lo, input int hi);
        checks++;
        if (val < lo || val > hi) begin
            errors++;
            $display("FAIL %s: got=%0d expected %0d..%0d", name, val, lo, hi);
        end
    endtask

    function automatic bit odd_parity(input logic [7:0] d);
        return ($countones(d) % 2) == 0;
    endfunction

    // Inhibit length and request ordering, observed from the outputs.
    always @(negedge clk) begin
        if (ps2_clk_oe === 1'b1) begin
            inh_cnt++;
        end else if (prev_oe === 1'b1) begin
            chk_range("inhibit_len", inh_cnt, (INH - 1) * DIV, INH * DIV + 2);
            chk("start_bit_before_release", ps2_data_oe, 1);
            t_release = cyc;
            inh_cnt   = 0;
        end
        prev_oe = ps2_clk_oe;
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (done === 1'b1 || err === 1'b1) begin
            chk("done_err_exclusive", done && err, 0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: done=%0b err=%0b expected none", done, err);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_kind_err", err, e.is_err);
                if (e.is_err) begin
                    chk("err_code", err_code, e.code);
                    chk("lines_released", {ps2_clk_oe, ps2_data_oe}, 0);
                    if (e.ref_sel == 1)
                        chk_range("start_timeout", cyc - t_release, (START_TO - 1) * DIV, START_TO * DIV + 4);
                    else if (e.ref_sel == 2)
                        chk_range("frame_timeout", cyc - t_first_fall, (FRAME_TO - 1) * DIV, FRAME_TO * DIV + 16);
                end else begin
                    chk("frame_bits", cap_frame, e.frame);
                    chk("err_code_clear", err_code, 0);
                end
            end
        end
    end

    task automatic device(input int n_edges, input bit ack_low, input int half,
                          input int glitch_after, input int reset_at);
        int w = 0;
        cap_frame = '0;
        while (!(ps2_clk_in == 1'b1 && ps2_data_in == 1'b0) && w < 4000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 4000) begin
            chk("request_seen", 0, 1);
            return;
        end
        repeat (half) @(negedge clk);
        for (int k = 1; k <= n_edges; k++) begin
            dev_clk_low = 1'b1;
            if (k == 1) t_first_fall = cyc;
            if (k == reset_at) begin
                repeat (20) @(negedge clk);
                chk("pre_reset_data_oe", ps2_data_oe, 1);
                rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
                chk("reset_lines_released", {ps2_clk_oe, ps2_data_oe}, 0);
                chk("reset_ready", {tx_ready, rx_inhibit}, 2'b10);
                repeat (half) @(negedge clk);
                dev_clk_low = 1'b0;
                return;
            end
            repeat (half) @(negedge clk);
            if (k <= 10) cap_frame[k-1] = ps2_data_in;
            dev_clk_low = 1'b0;
            if (k == glitch_after) begin
                repeat (half / 2) @(negedge clk);
                glitch = 1'b1;
                repeat (2) @(negedge clk);
                glitch = 1'b0;
                repeat (half - half / 2 - 2) @(negedge clk);
            end else if (k == 10 && ack_low) begin
                repeat (half / 2) @(negedge clk);
                dev_data_low = 1'b1;
                repeat (half - half / 2) @(negedge clk);
            end else begin
                repeat (half) @(negedge clk);
            end
        end
        if (n_edges == 11) begin
            repeat (half / 2) @(negedge clk);
            dev_data_low = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] d);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = d;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("ready_drops_after_accept", tx_ready, 0);
    endtask

    task automatic run(input logic [7:0] d, input int n_edges, input bit ack_low, input int half,
                       input int glitch_after, input int reset_at,
                       input bit is_err, input logic [1:0] code, input int ref_sel);
        exp_t x;
        int   w = 0;
        x.is_err  = is_err;
        x.code    = code;
        x.frame   = {1'b1, odd_parity(d), d};
        x.ref_sel = ref_sel;
        if (reset_at == 0) exp_q.push_back(x);
        send(d);
        device(n_edges, ack_low, half, glitch_after, reset_at);
        while (!(tx_ready === 1'b1 && exp_q.size() == 0) && w < 6000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 6000) begin
            checks++;
            errors++;
            $display("FAIL completion_timeout: pending=%0d tx_ready=%0b expected 0 pending, ready", exp_q.size(), tx_ready);
            exp_q.delete();
        end
        repeat (20) @(negedge clk);
    endtask

    initial begin
        rst      = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 8'hF4;
        repeat (3) @(negedge clk);
        chk("reset_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        chk("reset_ready_inhibit", {tx_ready, rx_inhibit}, 2'b10);
        chk("reset_pulses_code", {done, err, err_code}, 0);
        tx_valid = 1'b0;
        rst      = 1'b1;
        repeat (20) @(negedge clk);

        run(8'hF4, 11, 1'b1, 40, 0, 0, 1'b0, 2'b00, 0);
        run(8'hFF, 11, 1'b1, 40, 0, 0, 1'b0, 2'b00, 0);
        run(8'h00, 11, 1'b1, 40, 0, 0, 1'b0, 2'b00, 0);
        run(8'hF3, 0,  1'b1, 40, 0, 0, 1'b1, 2'b01, 1);
        run(8'hF4, 6,  1'b1, 40, 0, 0, 1'b1, 2'b10, 2);
        run(8'hF4, 11, 1'b0, 40, 0, 0, 1'b1, 2'b11, 0);
        run(8'h0F, 11, 1'b1, 40, 0, 5, 1'b0, 2'b00, 0);
        run(8'hFF, 11, 1'b1, 40, 0, 0, 1'b0, 2'b00, 0);
        run(8'hA5, 11, 1'b1, 40, 3, 0, 1'b0, 2'b00, 0);
        for (int i = 0; i < 5; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            run(d, 11, 1'b1, int'($urandom_range(30, 50)), 0, 0, 1'b0, 2'b00, 0);
        end

        chk("scoreboard_drained", exp_q.size(), 0);
        chk("final_idle", {tx_ready, ps2_clk_oe, ps2_data_oe}, 3'b100);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: cycles=%0d expected completion before 90000", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
